// File: rtl/uart_out_line_buffer.sv
// Line-assembling buffer behind the simulation UART port.
// Bytes go out as complete lines, or as a forced flush of a partial line.
module uart_out_line_buffer #(
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_ch,
  input  logic        flush_req,
  output logic        out_valid,
  output logic [7:0]  out_ch,
  output logic        out_last,
  input  logic        out_ready,
  output logic [31:0] line_count,
  output logic [31:0] drop_count,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_VAL   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, LINE, FLUSH} state_t;
  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wptr, rptr, count, flush_left;
  logic [PW-1:0] pending;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    head;
  logic          full, empty, push, pop, head_nl, timeout_hit;
  logic          valid_int, last_int, push_nl, pop_nl;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty       = (wptr == rptr);
  assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count       = wptr - rptr;
  assign head        = mem[rptr[AW-1:0]];
  assign head_nl     = (head == 8'h0A);
  assign push        = in_valid && !full;
  assign pop         = valid_int && out_ready;
  assign push_nl     = push && (in_ch == 8'h0A);
  assign pop_nl      = pop && head_nl;
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == TO_VAL);

  always_comb begin
    state_nxt = state;
    valid_int = 1'b0;
    last_int  = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0)
          state_nxt = LINE;
        else if (!empty && (flush_req || full || timeout_hit))
          state_nxt = FLUSH;
      end
      LINE: begin
        valid_int = !empty;
        last_int  = !empty && head_nl;
        if (pop_nl) state_nxt = IDLE;
      end
      FLUSH: begin
        valid_int = (flush_left != '0);
        last_int  = (flush_left == PTR_ONE);
        if (pop && flush_left == PTR_ONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = valid_int;
  assign out_ch    = valid_int ? head : 8'h00;
  assign out_last  = last_int;
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clock) begin
    if (!reset && push) mem[wptr[AW-1:0]] <= in_ch;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      pending    <= '0;
      idle_cnt   <= '0;
      flush_left <= '0;
      line_count <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      // Full is judged before any same-cycle pop, so this is still a drop.
      if (in_valid && full && drop_count != '1) drop_count <= drop_count + 32'd1;
      if (pop && last_int) line_count <= line_count + 32'd1;
      case ({push_nl, pop_nl})
        2'b10:   pending <= pending + PEND_ONE;
        2'b01:   pending <= pending - PEND_ONE;
        default: ;
      endcase
      if (push || empty)
        idle_cnt <= '0;
      else if (state == IDLE && idle_cnt != TO_VAL)
        idle_cnt <= idle_cnt + TO_ONE;
      if (state == IDLE && state_nxt == FLUSH)
        flush_left <= count;
      else if (state == FLUSH && pop)
        flush_left <= flush_left - PTR_ONE;
    end
  end

endmodule

// File: tb/tb_uart_out_line_buffer.sv
// Scoreboard bench for uart_out_line_buffer: a queue-based reference model predicts
// the byte stream; a negedge monitor compares every handshake and the status outputs.
module tb_uart_out_line_buffer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ch = 8'h00;
  logic        flush_req = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_last, busy;
  logic [7:0]  out_ch;
  logic [31:0] line_count, drop_count;

  uart_out_line_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ch(in_ch),
    .flush_req(flush_req), .out_valid(out_valid), .out_ch(out_ch),
    .out_last(out_last), .out_ready(out_ready), .line_count(line_count),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  logic [8:0] exp_q[$];

  // Reference model: the buffer is a byte queue; a line is ready whenever it holds a newline.
  byte unsigned mq[$];
  int           m_mode = 0;   // 0 waiting, 1 sending a line, 2 sending a flush
  int           m_fl = 0;
  int           m_idle = 0;
  int unsigned  m_drops = 0;
  int unsigned  m_lines = 0;
  bit           cur_valid = 1'b0, cur_busy = 1'b0;
  int unsigned  cur_lines = 0, cur_drops = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int newlines_held();
    int n = 0;
    foreach (mq[i]) if (mq[i] == 8'h0A) n++;
    return n;
  endfunction

  task automatic model_step(input bit v, input byte unsigned c, input bit fr,
                            input bit rdy, input bit rst);
    bit full, empty, valid, last, pop, push;
    int old_mode;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    valid = (m_mode == 1) ? !empty : (m_mode == 2) ? (m_fl != 0) : 1'b0;
    last  = (m_mode == 1) ? (!empty && mq[0] == 8'h0A) : (m_mode == 2 && m_fl == 1);
    cur_valid = valid;
    cur_busy  = (m_mode != 0) || !empty;
    cur_lines = m_lines;
    cur_drops = m_drops;
    if (rst) begin
      mq.delete();
      m_mode = 0; m_fl = 0; m_idle = 0; m_drops = 0; m_lines = 0;
      return;
    end
    pop  = valid && rdy;
    push = v && !full;
    if (v && full && m_drops != 32'hFFFF_FFFF) m_drops++;
    if (pop) begin
      exp_q.push_back({mq[0], last});
      if (last) m_lines++;
    end
    old_mode = m_mode;
    case (m_mode)
      0: begin
        if (newlines_held() > 0) m_mode = 1;
        else if (!empty && (fr || full || (TIMEOUT != 0 && m_idle == TIMEOUT))) begin
          m_mode = 2;
          m_fl = mq.size();
        end
      end
      1: if (pop && mq[0] == 8'h0A) m_mode = 0;
      default: if (pop) begin
        m_fl--;
        if (m_fl == 0) m_mode = 0;
      end
    endcase
    if (push || empty) m_idle = 0;
    else if (old_mode == 0 && m_idle < TIMEOUT) m_idle++;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(c);
  endtask

  task automatic step(input bit v, input byte unsigned c, input bit fr,
                      input bit rdy, input bit rst);
    @(posedge clock);
    #1;
    in_valid = v; in_ch = c; flush_req = fr; out_ready = rdy; reset = rst;
    model_step(v, c, fr, rdy, rst);
  endtask

  task automatic idle_steps(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy, 1'b0);
  endtask

  bit         hold_prev = 1'b0;
  logic [8:0] held = '0;
  logic [8:0] e;

  always @(negedge clock) begin
    if (checking) begin
      check("out_valid", out_valid, cur_valid);
      check("busy", busy, cur_busy);
      check("line_count", line_count, cur_lines);
      check("drop_count", drop_count, cur_drops);
      if (hold_prev) check("held_while_stalled", {out_valid, out_ch, out_last}, {1'b1, held});
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL handshake: unexpected byte 0x%0h last=%0b, expected none", out_ch, out_last);
        end else begin
          e = exp_q.pop_front();
          check("byte_and_last", {out_ch, out_last}, e);
        end
      end
      hold_prev = !reset && out_valid && !out_ready;
      held = {out_ch, out_last};
    end
  end

  initial begin
    bit v, fr, rdy, rst;
    byte unsigned c;
    int ph;

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checking = 1'b1;
    @(negedge clock);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_ch", out_ch, 0);
    check("reset_out_last", out_last, 0);
    check("reset_busy", busy, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // "hi\n": first out_valid two cycles after the newline cycle
    step(1'b1, 8'h68, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h69, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    check("latency_n_plus_1_valid", out_valid, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    check("latency_n_plus_2_valid", out_valid, 1);
    check("latency_n_plus_2_ch", out_ch, 8'h68);
    idle_steps(4, 1'b1);
    @(negedge clock);
    check("hello_lines", line_count, 1);

    // fill past full with the sink stalled
    for (int i = 0; i < 10; i++) step(1'b1, 8'h41 + i, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("full_drops", drop_count, 2);
    check("full_flush_valid", out_valid, 1);
    check("full_flush_first_last", out_last, 0);
    idle_steps(10, 1'b1);
    @(negedge clock);
    check("full_flush_lines", line_count, 2);

    // idle timeout flushes a partial line
    step(1'b1, 8'h61, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b1, 1'b0);
    idle_steps(10, 1'b1);
    @(negedge clock);
    check("timeout_not_yet", out_valid, 0);
    idle_steps(15, 1'b1);
    @(negedge clock);
    check("timeout_lines", line_count, 3);

    // two lines with a toggling sink
    step(1'b1, 8'h61, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b0, (i % 2) == 0, 1'b0);
    @(negedge clock);
    check("toggle_lines", line_count, 5);

    // reset in the middle of a line
    step(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h79, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("midreset_valid", out_valid, 0);
    check("midreset_lines", line_count, 0);
    check("midreset_busy", busy, 0);
    step(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0);
    idle_steps(4, 1'b1);
    @(negedge clock);
    check("after_reset_lines", line_count, 1);

    // newline enqueued on the edge that pops the previous newline
    step(1'b1, 8'h63, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0);
    idle_steps(2, 1'b1);
    step(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    check("overlap_pop_ch", out_ch, 8'h0A);
    check("overlap_pop_last", out_last, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    check("overlap_idle_gap", out_valid, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    check("overlap_second_line", {out_valid, out_ch}, {1'b1, 8'h0A});
    idle_steps(3, 1'b1);
    @(negedge clock);
    check("overlap_lines", line_count, 3);

    // randomized traffic in phases of differing sink throughput
    for (int i = 0; i < 3000; i++) begin
      ph  = (i / 300) % 4;
      rdy = $urandom_range(0, 99) < ((ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 10 : 70);
      v   = $urandom_range(0, 99) < ((ph == 2) ? 70 : 40);
      c   = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'(8'h41 + $urandom_range(0, 25));
      fr  = $urandom_range(0, 99) < 3;
      rst = $urandom_range(0, 999) == 0;
      step(v, c, fr, rdy, rst);
    end
    idle_steps(80, 1'b1);
    @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
